mxu_result_drain: RTL and testbench

MXU_RESULT_DRAIN -- requirements
Module: mxu_result_drain

---
 rtl/tpc_pkg.sv | 13 +
 rtl/drain_col_fifo.sv | 47 ++++
 rtl/mxu_result_drain.sv | 155 +++++++++++++++
 tb/tb_mxu_result_drain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// Shared tensor-core definitions: accumulator/array defaults and the result-drain FSM states.
package tpc_pkg;

  localparam int TPC_ACC_WIDTH  = 32;
  localparam int TPC_ARRAY_SIZE = 4;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_RUN  = 2'd1,
    DRAIN_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/drain_col_fifo.sv
// Per-column synchronous FIFO with full/empty; a push while full is accepted only if a pop frees a slot
// in the same cycle. DEPTH must be a power of two, at least 2.
module drain_col_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mxu_result_drain.sv
// Deskews systolic-array column results into full rows and writes them to SRAM at base + k*stride.
// Define MXU_DRAIN_RELU_EN to clamp negative column values to zero before packing.
module mxu_result_drain
  import tpc_pkg::*;
#(
  parameter int ARRAY_SIZE = TPC_ARRAY_SIZE,
  parameter int ACC_WIDTH  = TPC_ACC_WIDTH,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]            cfg_stride,
  input  logic [15:0]                      cfg_rows,
  input  logic [ARRAY_SIZE-1:0]            col_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  col_data,
  output logic                             o_we,
  output logic [ADDR_WIDTH-1:0]            o_addr,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  o_wdata,
  input  logic                             o_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int DW = ARRAY_SIZE * ACC_WIDTH;

  drain_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [15:0]           rows_q, rows_d;
  logic [15:0]           issued_q, issued_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  ovf_q, ovf_d;

  logic [ARRAY_SIZE-1:0] push, fifo_full, fifo_empty, ovf_evt;
  logic [DW-1:0]         fifo_dout, row_data;
  logic                  in_run, start_acc, row_complete, pop, xfer;

  assign in_run       = (state_q == DRAIN_RUN);
  assign start_acc    = (state_q == DRAIN_IDLE) && cfg_start;
  assign row_complete = ~|fifo_empty;
  assign push         = col_valid & {ARRAY_SIZE{in_run}};
  // A pop is only allowed when the output register is free or draining this cycle.
  assign pop          = in_run && row_complete && (issued_q != rows_q) && (!we_q || o_ready);
  assign xfer         = we_q && o_ready;
  assign ovf_evt      = push & fifo_full & ~{ARRAY_SIZE{pop}};

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
    drain_col_fifo #(
      .WIDTH (ACC_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (start_acc),
      .push_i  (push[j]),
      .data_i  (col_data[j*ACC_WIDTH +: ACC_WIDTH]),
      .pop_i   (pop),
      .data_o  (fifo_dout[j*ACC_WIDTH +: ACC_WIDTH]),
      .full_o  (fifo_full[j]),
      .empty_o (fifo_empty[j])
    );

`ifdef MXU_DRAIN_RELU_EN
    assign row_data[j*ACC_WIDTH +: ACC_WIDTH] =
      fifo_dout[j*ACC_WIDTH + ACC_WIDTH - 1] ? '0 : fifo_dout[j*ACC_WIDTH +: ACC_WIDTH];
`else
    assign row_data[j*ACC_WIDTH +: ACC_WIDTH] = fifo_dout[j*ACC_WIDTH +: ACC_WIDTH];
`endif
  end

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    next_addr_d = next_addr_q;
    rows_d      = rows_q;
    issued_d    = issued_q;
    xfer_cnt_d  = xfer_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (cfg_start) begin
          stride_d    = cfg_stride;
          next_addr_d = cfg_base_addr;
          rows_d      = cfg_rows;
          issued_d    = '0;
          xfer_cnt_d  = '0;
          ovf_d       = 1'b0;
          state_d     = (cfg_rows == '0) ? DRAIN_DONE : DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        if (|ovf_evt) ovf_d = 1'b1;
        if (xfer) begin
          we_d       = 1'b0;
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          if (xfer_cnt_d == rows_q) state_d = DRAIN_DONE;
        end
        if (pop) begin
          we_d        = 1'b1;
          addr_d      = next_addr_q;
          wdata_d     = row_data;
          next_addr_d = next_addr_q + stride_q;
          issued_d    = issued_q + 16'd1;
        end
      end
      DRAIN_DONE: state_d = DRAIN_IDLE;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DRAIN_IDLE;
      stride_q    <= '0;
      next_addr_q <= '0;
      rows_q      <= '0;
      issued_q    <= '0;
      xfer_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      next_addr_q <= next_addr_d;
      rows_q      <= rows_d;
      issued_q    <= issued_d;
      xfer_cnt_q  <= xfer_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ovf_q       <= ovf_d;
    end
  end

  // Masking with rst keeps a reset cycle from ever looking like a write to the SRAM.
  assign o_we     = we_q && !rst;
  assign o_addr   = addr_q;
  assign o_wdata  = wdata_q;
  assign busy     = in_run;
  assign done     = (state_q == DRAIN_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mxu_result_drain.sv
// Randomized bench for mxu_result_drain: row k must be the k-th accepted value of every column at base + k*stride.
module tb_mxu_result_drain;

  localparam int AS  = 4;
  localparam int ACW = 32;
  localparam int ADW = 20;
  localparam int FD  = 4;
  localparam int DW  = AS * ACW;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [ADW-1:0]  cfg_base_addr, cfg_stride;
  logic [15:0]     cfg_rows;
  logic [AS-1:0]   col_valid;
  logic [DW-1:0]   col_data;
  logic            o_we;
  logic [ADW-1:0]  o_addr;
  logic [DW-1:0]   o_wdata;
  logic            o_ready;
  logic            busy, done, overflow;

  mxu_result_drain #(
    .ARRAY_SIZE (AS),
    .ACC_WIDTH  (ACW),
    .ADDR_WIDTH (ADW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_stride    (cfg_stride),
    .cfg_rows      (cfg_rows),
    .col_valid     (col_valid),
    .col_data      (col_data),
    .o_we          (o_we),
    .o_addr        (o_addr),
    .o_wdata       (o_wdata),
    .o_ready       (o_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-column queues of accepted values plus the run configuration.
  logic [ACW-1:0] colq [AS][$];
  logic [ADW-1:0] exp_base, exp_stride;
  int             exp_rows;
  int             xfer_idx;
  int             done_cnt;
  bit             model_on = 1'b0;
  logic [ADW-1:0] first_addr, last_addr;
  logic [DW-1:0]  first_data, last_data;

  logic           prev_we = 1'b0, prev_ready = 1'b0;
  logic [ADW-1:0] prev_addr;
  logic [DW-1:0]  prev_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ACW-1:0] relu(input logic [ACW-1:0] v);
`ifdef MXU_DRAIN_RELU_EN
    return v[ACW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_row(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < AS; j++) r[j*ACW +: ACW] = relu(colq[j][k]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (model_on) begin
        if (prev_we && !prev_ready) begin
          check("hold_we", DW'(o_we), DW'(1));
          check("hold_addr", DW'(o_addr), DW'(prev_addr));
          check("hold_wdata", o_wdata, prev_data);
        end
        if (o_we && o_ready) begin
          bit have_data;
          have_data = 1'b1;
          for (int j = 0; j < AS; j++) if (colq[j].size() <= xfer_idx) have_data = 1'b0;
          if (xfer_idx >= exp_rows) begin
            check("extra_write", DW'(xfer_idx + 1), DW'(exp_rows));
          end else if (!have_data) begin
            check("write_without_data", DW'(xfer_idx), DW'(-1));
          end else begin
            logic [ADW-1:0] ea;
            ea = exp_base + ADW'(xfer_idx) * exp_stride;
            check("write_addr", DW'(o_addr), DW'(ea));
            check("write_data", o_wdata, exp_row(xfer_idx));
            if (xfer_idx == 0) begin
              first_addr = o_addr;
              first_data = o_wdata;
            end
            last_addr = o_addr;
            last_data = o_wdata;
          end
          xfer_idx++;
        end
        if (done) begin
          check("done_after_all_writes", DW'(xfer_idx), DW'(exp_rows));
          done_cnt++;
        end
      end
      prev_we    = o_we;
      prev_ready = o_ready;
      prev_addr  = o_addr;
      prev_data  = o_wdata;
    end
  end

  function automatic void model_start(input logic [ADW-1:0] base, input logic [ADW-1:0] stride,
                                      input int rows);
    for (int j = 0; j < AS; j++) colq[j].delete();
    exp_base   = base;
    exp_stride = stride;
    exp_rows   = rows;
    xfer_idx   = 0;
    done_cnt   = 0;
    model_on   = 1'b1;
  endfunction

  // mode 0: random pushes/ready plus a stray cfg_start; 1: skewed 1..rows; 2: skewed with a 5-cycle stall;
  // 3: random with -10 as the first column-0 value. abort_at >= 0 resets after that many writes.
  task automatic do_run(input logic [ADW-1:0] base, input logic [ADW-1:0] stride, input int rows,
                        input int mode, input int abort_at);
    int pushed [AS];
    bit finished;
    model_start(base, stride, rows);
    cfg_base_addr = base;
    cfg_stride    = stride;
    cfg_rows      = 16'(rows);
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("busy_after_start", DW'(busy), DW'(1));
    for (int j = 0; j < AS; j++) pushed[j] = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (abort_at >= 0 && xfer_idx >= abort_at) begin
        model_on  = 1'b0;
        col_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_we", DW'(o_we), DW'(0));
        check("abort_addr", DW'(o_addr), DW'(0));
        check("abort_wdata", o_wdata, DW'(0));
        check("abort_busy", DW'(busy), DW'(0));
        check("abort_done", DW'(done), DW'(0));
        check("abort_overflow", DW'(overflow), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      col_valid = '0;
      for (int j = 0; j < AS; j++) begin
        bit go;
        go = (mode == 1 || mode == 2) ? (cyc >= j) : ($urandom_range(0, 99) < 70);
        if (go && pushed[j] < rows && pushed[j] - xfer_idx < FD) begin
          logic [ACW-1:0] v;
          if (mode == 1)                              v = ACW'(pushed[j] + 1);
          else if (mode == 3 && j == 0 && pushed[j] == 0) v = 32'hFFFF_FFF6;
          else                                        v = $urandom;
          col_valid[j]            = 1'b1;
          col_data[j*ACW +: ACW]  = v;
          colq[j].push_back(v);
          pushed[j]++;
        end
      end
      case (mode)
        0:       o_ready = ($urandom_range(0, 3) != 0);
        2:       o_ready = !(cyc >= 5 && cyc < 10);
        default: o_ready = 1'b1;
      endcase
      if (mode == 0 && cyc == 3) begin
        cfg_start     = 1'b1;
        cfg_base_addr = ADW'($urandom);
      end else begin
        cfg_start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt > 0) finished = 1'b1;
    end
    if (!finished) check("done_timeout", DW'(0), DW'(1));
    col_valid = '0;
    cfg_start = 1'b0;
    o_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("run_done_count", DW'(done_cnt), DW'(1));
    check("run_write_count", DW'(xfer_idx), DW'(rows));
    check("run_busy_end", DW'(busy), DW'(0));
    check("run_overflow", DW'(overflow), DW'(0));
    model_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_stride = '0; cfg_rows = '0;
    col_valid = '0; col_data = '0; o_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", DW'(o_we), DW'(0));
    check("rst_addr", DW'(o_addr), DW'(0));
    check("rst_wdata", o_wdata, DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_overflow", DW'(overflow), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    do_run(20'h00020, 20'h1, 4, 1, -1);
    check("gemm_first_addr", DW'(first_addr), DW'(20'h00020));
    check("gemm_first_row", first_data, {32'd1, 32'd1, 32'd1, 32'd1});
    check("gemm_last_addr", DW'(last_addr), DW'(20'h00023));
    check("gemm_last_row", last_data, {32'd4, 32'd4, 32'd4, 32'd4});

    do_run(20'h00100, 20'h4, 4, 2, -1);
    check("stall_last_addr", DW'(last_addr), DW'(20'h0010C));

    do_run(20'hFFFFE, 20'h1, 3, 0, -1);
    check("wrap_first_addr", DW'(first_addr), DW'(20'hFFFFE));
    check("wrap_last_addr", DW'(last_addr), DW'(20'h00000));

    do_run(20'h00040, 20'h2, 2, 3, -1);
`ifdef MXU_DRAIN_RELU_EN
    check("neg_value_col0", DW'(first_data[31:0]), DW'(32'h0000_0000));
`else
    check("neg_value_col0", DW'(first_data[31:0]), DW'(32'hFFFF_FFF6));
`endif

    do_run(20'h00010, 20'h1, 4, 1, 2);

    // Zero-row job completes without writing.
    model_start(20'h0, 20'h1, 0);
    cfg_rows = 16'd0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check("rows0_done", DW'(done), DW'(1));
    check("rows0_we", DW'(o_we), DW'(0));
    @(posedge clk);
    @(negedge clk);
    check("rows0_done_pulse", DW'(done), DW'(0));
    check("rows0_done_count", DW'(done_cnt), DW'(1));
    model_on = 1'b0;

    // Overflow: only column 0 pushes, so no row completes and its FIFO fills.
    cfg_rows = 16'd4; cfg_base_addr = '0; cfg_start = 1'b1; o_ready = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < FD; i++) begin
      col_valid = 4'b0001; col_data = DW'($urandom);
      @(posedge clk); #1;
    end
    col_valid = '0;
    @(negedge clk);
    check("ovf_full_no_flag", DW'(overflow), DW'(0));
    @(posedge clk); #1;
    col_valid = 4'b0001;
    @(posedge clk); #1;
    col_valid = '0;
    @(negedge clk);
    check("ovf_set", DW'(overflow), DW'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ovf_sticky", DW'(overflow), DW'(1));
    check("ovf_no_write", DW'(o_we), DW'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ovf_cleared_by_rst", DW'(overflow), DW'(0));
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++)
      do_run(ADW'($urandom), ADW'($urandom), $urandom_range(1, 12), 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
